cu_mem_responder: RTL and testbench



---
 rtl/cu_mem_pkg.sv | 21 ++
 rtl/mem_byte_array.sv | 28 ++
 rtl/cu_mem_responder.sv | 105 ++++++++++
 tb/tb_cu_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_mem_pkg.sv
// Shared encodings for the control-unit memory bus: FSM states, rw/bw codes,
// and the captured request record.
package cu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam int   CNT_W     = 4;

  typedef struct packed {
    logic        rw;
    logic        bw;
    logic [15:0] data;
  } req_t;

  function automatic logic is_misaligned(input logic bw, input logic a0);
    return (bw == SIZE_WORD) && a0;
  endfunction
endpackage

// File: rtl/mem_byte_array.sv
// Two byte-wide banks: lane 0 holds even addresses, lane 1 odd addresses,
// both indexed by A[ADDR_W-1:1]. Synchronous write, registered read.
module mem_byte_array #(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-2:0]     idx,
  input  logic [1:0]            we,
  input  logic [1:0]            re,
  input  logic [1:0][7:0]       wdata,
  output logic [1:0][7:0]       rdata
);
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [7:0] mem [2**(ADDR_W-1)];
    logic [7:0] rd_q;

    // storage is intentionally left unreset; only the read register clears
    always_ff @(posedge clk)
      if (we[b]) mem[idx] <= wdata[b];

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)     rd_q <= '0;
      else if (re[b]) rd_q <= mem[idx];

    assign rdata[b] = rd_q;
  end
endmodule

// File: rtl/cu_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a
// byte/word access on a little-endian store with a single-cycle done pulse.
module cu_mem_responder
  import cu_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rw,
  input  logic              bw,
  input  logic [ADDR_W-1:0] mar,
  input  logic [15:0]       mdr_in,
  output logic [15:0]       mdr_out,
  output logic              done,
  output logic              fault,
  output logic              busy
);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state, nstate;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  req_t              req_q;
  logic              fault_q, zero_q, sel_byte_q, sel_odd_q;
  logic              access, misal;
  logic [1:0]        lanes, we, re;
  logic [1:0][7:0]   wdata, rdata;

  assign access = (state == WAIT) && (cnt == '0);
  assign misal  = is_misaligned(req_q.bw, addr_q[0]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (ena) nstate = WAIT;
      WAIT:    if (cnt == '0) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == RESP);
    fault    = done && fault_q;
    lanes    = (req_q.bw == SIZE_BYTE) ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
    wdata[0] = req_q.data[7:0];
    wdata[1] = (req_q.bw == SIZE_BYTE) ? req_q.data[7:0] : req_q.data[15:8];
    we       = '0;
    re       = '0;
    if (access && !misal) begin
      if (req_q.rw == RW_WRITE) we = lanes;
      else                      re = lanes;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      addr_q     <= '0;
      req_q      <= '0;
      fault_q    <= 1'b0;
      zero_q     <= 1'b0;
      sel_byte_q <= 1'b0;
      sel_odd_q  <= 1'b0;
    end else begin
      if (state == IDLE && ena) begin
        addr_q <= mar;
        req_q  <= req_t'{rw: rw, bw: bw, data: mdr_in};
        cnt    <= WAIT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) fault_q <= misal;
      // read-lane selection only moves on reads/faults so mdr_out holds across writes
      if (access && (req_q.rw == RW_READ || misal)) begin
        zero_q     <= misal;
        sel_byte_q <= req_q.bw;
        sel_odd_q  <= addr_q[0];
      end
    end

  mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (addr_q[ADDR_W-1:1]),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    if (zero_q)          mdr_out = '0;
    else if (sel_byte_q) mdr_out = {8'h00, sel_odd_q ? rdata[1] : rdata[0]};
    else                 mdr_out = {rdata[1], rdata[0]};
  end
endmodule

// File: tb/tb_cu_mem_responder.sv
// Scoreboard bench for cu_mem_responder: expectations are computed from a byte
// model at issue time and compared when done is observed.
module tb_cu_mem_responder;
  import cu_mem_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, rw = 1'b0, bw = 1'b0;
  logic [15:0] mar = '0, mdr_in = '0;
  logic [15:0] mdr_out;
  logic        done, fault, busy;

  int checks = 0, failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        fault;
    logic        rd;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model [int];

  always #5 clk = ~clk;

  cu_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rw(rw), .bw(bw), .mar(mar),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .done(done), .fault(fault), .busy(busy)
  );

  function automatic logic [7:0] mrd(input int a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic exp_t expect_of(input logic rw_i, bw_i, input logic [15:0] a);
    exp_t e;
    e.fault = (bw_i == SIZE_WORD) && a[0];
    e.rd    = (rw_i == RW_READ) || e.fault;
    if (e.fault)               e.data = 16'h0000;
    else if (bw_i == SIZE_BYTE) e.data = {8'h00, mrd(int'(a))};
    else                        e.data = {mrd(int'(a) + 1), mrd(int'(a))};
    return e;
  endfunction

  function automatic void model_wr(input logic bw_i, input logic [15:0] a, d);
    model[int'(a)] = d[7:0];
    if (bw_i == SIZE_WORD) model[int'(a) + 1] = d[15:8];
  endfunction

  // drive one request through an IDLE accept edge; returns at the negedge after accept
  task automatic issue(input logic rw_i, bw_i, input logic [15:0] a, d);
    sbq.push_back(expect_of(rw_i, bw_i, a));
    @(negedge clk); ena = 1'b1; rw = rw_i; bw = bw_i; mar = a; mdr_in = d;
    @(negedge clk); ena = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [15:0] d, output logic f);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    d = mdr_out; f = fault;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mdr_out, done, fault, busy} !== 19'h0) begin
      failures++;
      $display("FAIL reset mdr_out=%h done=%b fault=%b busy=%b expected all zero", mdr_out, done, fault, busy);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    int lat; logic [15:0] d; logic f; exp_t e;
    issue(RW_WRITE, SIZE_WORD, 16'h0100, 16'h1234);
    wait_done(lat, d, f); e = sbq.pop_front();
    checks++;
    if (lat !== 3 || f !== e.fault) begin
      failures++; $display("FAIL word_wr lat=%0d fault=%b expected lat=3 fault=%b", lat, f, e.fault);
    end
    model_wr(SIZE_WORD, 16'h0100, 16'h1234);
    issue(RW_READ, SIZE_WORD, 16'h0100, 16'h0000);
    wait_done(lat, d, f); e = sbq.pop_front();
    checks++;
    if (lat !== 3 || f !== e.fault || d !== e.data) begin
      failures++;
      $display("FAIL word_rd lat=%0d fault=%b data=%h expected lat=3 fault=%b data=%h", lat, f, d, e.fault, e.data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mdr_out !== e.data) begin
      failures++; $display("FAIL rd_hold done=%b mdr_out=%h expected done=0 mdr_out=%h", done, mdr_out, e.data);
    end
  endtask

  task automatic test_byte();
    int lat; logic [15:0] d; logic f; exp_t e;
    logic [15:0] addrs [3] = '{16'h0100, 16'h0100, 16'h0101};
    logic        bws   [3] = '{SIZE_WORD, SIZE_BYTE, SIZE_BYTE};
    issue(RW_WRITE, SIZE_BYTE, 16'h0101, 16'hFFAB);
    wait_done(lat, d, f); void'(sbq.pop_front());
    model_wr(SIZE_BYTE, 16'h0101, 16'hFFAB);
    for (int i = 0; i < 3; i++) begin
      issue(RW_READ, bws[i], addrs[i], 16'h0000);
      wait_done(lat, d, f); e = sbq.pop_front();
      checks++;
      if (lat !== 3 || f !== 1'b0 || d !== e.data) begin
        failures++;
        $display("FAIL byte_rd%0d lat=%0d fault=%b data=%h expected lat=3 fault=0 data=%h", i, lat, f, d, e.data);
      end
    end
  endtask

  task automatic test_fault();
    int lat; logic [15:0] d; logic f; exp_t e;
    issue(RW_WRITE, SIZE_WORD, 16'h0102, 16'hC0DE);
    wait_done(lat, d, f); void'(sbq.pop_front());
    model_wr(SIZE_WORD, 16'h0102, 16'hC0DE);
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? RW_READ : RW_WRITE, SIZE_WORD, 16'h0103, 16'h9999);
      wait_done(lat, d, f); e = sbq.pop_front();
      checks++;
      if (lat !== 3 || f !== 1'b1 || done !== 1'b1 || d !== 16'h0000) begin
        failures++;
        $display("FAIL fault%0d lat=%0d fault=%b done=%b data=%h expected lat=3 fault=1 done=1 data=0000", i, lat, f, done, d);
      end
      @(negedge clk);
      checks++;
      if (fault !== 1'b0) begin
        failures++; $display("FAIL fault_len%0d fault=%b expected 0 after RESP", i, fault);
      end
    end
    issue(RW_READ, SIZE_WORD, 16'h0102, 16'h0000);
    wait_done(lat, d, f); e = sbq.pop_front();
    checks++;
    if (d !== e.data || f !== 1'b0) begin
      failures++; $display("FAIL fault_nowrite data=%h fault=%b expected data=%h fault=0", d, f, e.data);
    end
  endtask

  task automatic test_back_to_back();
    int npulse = 0; exp_t e;
    for (int i = 0; i < 4; i++) sbq.push_back(expect_of(RW_READ, SIZE_WORD, 16'h0100));
    @(negedge clk); @(negedge clk);
    ena = 1'b1; rw = RW_READ; bw = SIZE_WORD; mar = 16'h0100;
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      checks++;
      if (done !== ((j % 5 == 3) && j < 20) || busy !== ((j < 19) && (j % 5 != 4))) begin
        failures++;
        $display("FAIL b2b_cyc%0d done=%b busy=%b expected done=%b busy=%b", j, done, busy,
                 (j % 5 == 3) && j < 20, (j < 19) && (j % 5 != 4));
      end
      if (done === 1'b1 && sbq.size() > 0) begin
        npulse++; e = sbq.pop_front();
        checks++;
        if (mdr_out !== e.data) begin
          failures++; $display("FAIL b2b_data%0d got=%h expected=%h", npulse, mdr_out, e.data);
        end
      end
      if (j == 15) ena = 1'b0;
    end
    checks++;
    if (npulse !== 4) begin
      failures++; $display("FAIL b2b_pulses got=%0d expected=4", npulse);
    end
    sbq.delete();
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] d; logic f; exp_t e;
    issue(RW_WRITE, SIZE_WORD, 16'h0200, 16'h5555);
    wait_done(lat, d, f); void'(sbq.pop_front());
    model_wr(SIZE_WORD, 16'h0200, 16'h5555);
    issue(RW_WRITE, SIZE_WORD, 16'h0200, 16'hFFFF);
    void'(sbq.pop_back());
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy busy=%b expected 1 before reset", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mdr_out, done, fault, busy} !== 19'h0) begin
      failures++;
      $display("FAIL mid_reset mdr_out=%h done=%b fault=%b busy=%b expected all zero", mdr_out, done, fault, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    issue(RW_READ, SIZE_WORD, 16'h0200, 16'h0000);
    wait_done(lat, d, f); e = sbq.pop_front();
    checks++;
    if (d !== e.data || lat !== 3) begin
      failures++; $display("FAIL mid_retain data=%h lat=%0d expected data=%h lat=3", d, lat, e.data);
    end
  endtask

  task automatic test_top_addr();
    int lat; logic [15:0] d; logic f; exp_t e;
    logic [15:0] addrs [2] = '{16'hFFFE, 16'h0000};
    issue(RW_WRITE, SIZE_WORD, 16'h0000, 16'h7777);
    wait_done(lat, d, f); void'(sbq.pop_front());
    model_wr(SIZE_WORD, 16'h0000, 16'h7777);
    issue(RW_WRITE, SIZE_WORD, 16'hFFFE, 16'hBEEF);
    mar = 16'h0000; mdr_in = 16'h1111; bw = SIZE_BYTE;
    wait_done(lat, d, f); e = sbq.pop_front();
    checks++;
    if (f !== 1'b0 || lat !== 3) begin
      failures++; $display("FAIL top_wr fault=%b lat=%0d expected fault=0 lat=3", f, lat);
    end
    model_wr(SIZE_WORD, 16'hFFFE, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      issue(RW_READ, SIZE_WORD, addrs[i], 16'h0000);
      wait_done(lat, d, f); e = sbq.pop_front();
      checks++;
      if (d !== e.data || f !== 1'b0) begin
        failures++; $display("FAIL top_rd%0d data=%h fault=%b expected data=%h fault=0", i, d, f, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_top_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
